// File: rtl/cim_pkg.sv
// -----------------------------------------------------------------------------
// cim_pkg
// Shared types and helpers for the CIM input-side blocks.
//   t_cim_rx_state : receiver FSM states (load vector, stream planes, wait done)
//   idx_width(n)   : width of an index over n items, never less than 1 bit
// -----------------------------------------------------------------------------
package cim_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_STREAM,
    S_WAIT
  } t_cim_rx_state;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cim_rx_bitplane.sv
// -----------------------------------------------------------------------------
// cim_rx_bitplane
// Combinational bit-plane extraction from the crossbar row buffer.
//   i_rows      : row buffer, one datatype_size element per crossbar row
//   i_bit_idx   : plane index b to extract
//   o_plane     : bit r = bit b of row r; rows >= input_rows always read 0
//   o_all_zero  : 1 when every bit of o_plane is 0
// -----------------------------------------------------------------------------
module cim_rx_bitplane
  import cim_pkg::*;
#(
  parameter int datatype_size = 8,
  parameter int xbar_size     = 256,
  parameter int input_rows    = 45,
  localparam int BW           = idx_width(datatype_size)
) (
  input  logic [datatype_size-1:0] i_rows [xbar_size],
  input  logic [BW-1:0]            i_bit_idx,
  output logic [xbar_size-1:0]     o_plane,
  output logic                     o_all_zero
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_plane = '0;
    for (int r = 0; r < input_rows; r++) begin
      o_plane[r] = i_rows[r][i_bit_idx];
    end
    o_all_zero = ~|o_plane;
  end

endmodule

// File: rtl/cim_input_rx.sv
// -----------------------------------------------------------------------------
// cim_input_rx
// Receiving end of the CIM input-write interface. Captures one input vector
// into a crossbar-wide row buffer, streams it bit-serially (LSB plane first)
// to the crossbar, then holds busy until the output side reports compute done.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_we/i_addr/i_data : row write from the convolution controller
//   o_busy          : vector captured / in compute; writes are dropped
//   o_plane         : current bit-plane (0 whenever o_plane_valid is 0)
//   o_plane_valid   : o_plane/o_bit_idx valid
//   o_bit_idx       : index of presented plane
//   i_plane_ack     : crossbar consumed the presented plane
//   i_compute_done  : output side finished accumulating the vector
//   o_overrun       : sticky, a write arrived while busy
//
// Configuration macro
//   CIM_RX_ZERO_SKIP_EN : all-zero planes are skipped without presentation,
//                         one plane per cycle; if no non-zero plane remains
//                         the FSM goes straight to S_WAIT.
// -----------------------------------------------------------------------------
module cim_input_rx
  import cim_pkg::*;
#(
  parameter int datatype_size = 8,
  parameter int xbar_size     = 256,
  parameter int input_rows    = 45,
  localparam int AW           = idx_width(xbar_size),
  localparam int BW           = idx_width(datatype_size)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_addr,
  input  logic [datatype_size-1:0] i_data,
  output logic                     o_busy,
  output logic [xbar_size-1:0]     o_plane,
  output logic                     o_plane_valid,
  output logic [BW-1:0]            o_bit_idx,
  input  logic                     i_plane_ack,
  input  logic                     i_compute_done,
  output logic                     o_overrun
);

  localparam int             CW        = $clog2(input_rows + 1);
  localparam logic [CW-1:0]  ROWS_LAST = CW'(input_rows - 1);
  localparam logic [AW:0]    ROWS_LIM  = (AW + 1)'(input_rows);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(datatype_size - 1);

  t_cim_rx_state            state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic [BW-1:0]            bit_idx_q, bit_idx_d;
  logic                     busy_q, busy_d;
  logic                     plane_valid_q, plane_valid_d;
  logic                     overrun_q, overrun_d;
  logic [datatype_size-1:0] buf_q [xbar_size];
  logic [datatype_size-1:0] buf_d [xbar_size];

  logic [xbar_size-1:0]     plane;
  logic                     present;

`ifdef CIM_RX_ZERO_SKIP_EN
  logic                     plane_zero;
  logic [datatype_size-1:0] col_nz;
  logic                     more_planes;
`else
  logic                     unused_plane_zero;
`endif

  cim_rx_bitplane #(
    .datatype_size (datatype_size),
    .xbar_size     (xbar_size),
    .input_rows    (input_rows)
  ) u_bitplane (
    .i_rows     (buf_q),
    .i_bit_idx  (bit_idx_q),
    .o_plane    (plane),
`ifdef CIM_RX_ZERO_SKIP_EN
    .o_all_zero (plane_zero)
`else
    .o_all_zero (unused_plane_zero)
`endif
  );

`ifdef CIM_RX_ZERO_SKIP_EN
  // col_nz[b] is set when plane b has any 1 bit; more_planes tells whether a
  // non-zero plane exists above the current index.
  always_comb begin
    col_nz = '0;
    for (int r = 0; r < input_rows; r++) begin
      col_nz = col_nz | buf_q[r];
    end
    more_planes = 1'b0;
    for (int b = 0; b < datatype_size; b++) begin
      if (b > int'(bit_idx_q)) more_planes = more_planes | col_nz[b];
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    bit_idx_d     = bit_idx_q;
    busy_d        = busy_q;
    plane_valid_d = plane_valid_q;
    buf_d         = buf_q;
    overrun_d     = overrun_q | (i_we & busy_q);

    case (state_q)
      S_LOAD: begin
        if (i_we) begin
          buf_d[i_addr] = i_data;
          // Rows outside the vector are stored but never complete it.
          if ({1'b0, i_addr} < ROWS_LIM) begin
            count_d = count_q + 1'b1;
            if (count_q == ROWS_LAST) begin
              state_d       = S_STREAM;
              busy_d        = 1'b1;
              plane_valid_d = 1'b1;
              bit_idx_d     = '0;
            end
          end
        end
      end

      S_STREAM: begin
`ifdef CIM_RX_ZERO_SKIP_EN
        if (plane_zero || i_plane_ack) begin
          if (more_planes) begin
            bit_idx_d = bit_idx_q + 1'b1;
          end else begin
            state_d       = S_WAIT;
            plane_valid_d = 1'b0;
            bit_idx_d     = '0;
          end
        end
`else
        if (i_plane_ack) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d       = S_WAIT;
            plane_valid_d = 1'b0;
            bit_idx_d     = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
`endif
      end

      S_WAIT: begin
        if (i_compute_done) begin
          state_d = S_LOAD;
          busy_d  = 1'b0;
          count_d = '0;
          for (int r = 0; r < xbar_size; r++) buf_d[r] = '0;
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_LOAD;
      count_q       <= '0;
      bit_idx_q     <= '0;
      busy_q        <= 1'b0;
      plane_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      // NOTE: the row buffer must read 0 after reset, so it is a reset flop
      // array rather than a RAM macro.
      for (int r = 0; r < xbar_size; r++) buf_q[r] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q       <= state_d;
      count_q       <= count_d;
      bit_idx_q     <= bit_idx_d;
      busy_q        <= busy_d;
      plane_valid_q <= plane_valid_d;
      overrun_q     <= overrun_d;
      for (int r = 0; r < xbar_size; r++) buf_q[r] <= buf_d[r];
    end
  end

`ifdef CIM_RX_ZERO_SKIP_EN
  assign present = plane_valid_q & ~plane_zero;
`else
  assign present = plane_valid_q;
`endif

  assign o_busy        = busy_q;
  assign o_plane_valid = present;
  assign o_plane       = present ? plane : '0;
  assign o_bit_idx     = bit_idx_q;
  assign o_overrun     = overrun_q;

endmodule
